led_seq_ctrl: RTL

Pattern sequencer and controller for the 8-LED bar. It replaces a fixed free-running shift pattern with a run/pause/step-controlled scheduler. It generates a programmable-rate tick, selects one of four display patterns, and sequences `LEDOut` through it. It sits between the board switches/debounced buttons and the LED pins.

---
 rtl/led_seq_if.sv | 23 ++
 rtl/led_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_seq_if.sv
// Control and display bundle between the switch/button front end and the LED
// sequencer.
interface led_seq_if;
    logic       run;
    logic       step;
    logic       clear;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [7:0] LEDOut;
    logic [1:0] state;
    logic       tick;
    logic       wrap;

    modport master (
        output run, step, clear, mode, speed,
        input  LEDOut, state, tick, wrap
    );

    modport slave (
        input  run, step, clear, mode, speed,
        output LEDOut, state, tick, wrap
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// Run/pause/step scheduler for the 8-LED bar: a prescaled tick steps one of
// four display patterns (FILL, CHASE, BOUNCE, BLINK).
module led_seq_ctrl #(
    parameter int unsigned TICK_DIV = 32'd50000000
) (
    input  logic      clk,
    input  logic      rst,
    led_seq_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_RUN      = 2'b01;
    localparam logic [1:0] ST_PAUSE    = 2'b10;

    localparam logic [1:0] MODE_FILL   = 2'b00;
    localparam logic [1:0] MODE_CHASE  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    logic [7:0]  led_q, led_d;
    logic [1:0]  state_q, state_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;
    logic [31:0] q_q, q_d;
    logic [1:0]  act_mode_q, act_mode_d;
    logic        dir_q, dir_d;

    logic [31:0] limit_s;
    logic        due_s;
    logic [9:0]  adv_s;

    function automatic logic [7:0] start_value(input logic [1:0] m);
        logic [7:0] v;
        case (m)
            MODE_CHASE:  v = 8'h01;
            MODE_BOUNCE: v = 8'h01;
            default:     v = 8'h00;
        endcase
        return v;
    endfunction

    // Returns {wrap, next_dir, next_led} for one advance of pattern m.
    function automatic logic [9:0] advance(input logic [1:0] m, input logic [7:0] led,
                                           input logic dir);
        logic [7:0] nxt;
        logic       nd;
        logic       wr;
        nxt = led;
        nd  = dir;
        wr  = 1'b0;
        case (m)
            MODE_FILL: begin
                if (led == 8'hFF) begin
                    nxt = 8'h00;
                    wr  = 1'b1;
                end else begin
                    nxt = {led[6:0], 1'b1};
                end
            end
            MODE_CHASE: begin
                nxt = {led[6:0], led[7]};
                wr  = (led == 8'h80);
            end
            MODE_BOUNCE: begin
                if (!dir) begin
                    nxt = {led[6:0], 1'b0};
                    nd  = (nxt == 8'h80);
                end else begin
                    nxt = {1'b0, led[7:1]};
                    nd  = (nxt != 8'h01);
                    wr  = (nxt == 8'h01);
                end
            end
            MODE_BLINK: begin
                nxt = ~led;
                wr  = (led == 8'hFF);
            end
            default: begin
                nxt = 8'h00;
                nd  = 1'b0;
            end
        endcase
        return {wr, nd, nxt};
    endfunction

    // Next-state logic: clear > mode restart > run transition > advance.
    always_comb begin
        limit_s    = TICK_DIV >> bus.speed;
        due_s      = (q_q >= (limit_s - 32'd1));
        adv_s      = advance(act_mode_q, led_q, dir_q);
        led_d      = led_q;
        state_d    = state_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        q_d        = q_q;
        act_mode_d = act_mode_q;
        dir_d      = dir_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
            led_d   = 8'h00;
            q_d     = 32'd0;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_d = 8'h00;
                    q_d   = 32'd0;
                    dir_d = 1'b0;
                    if (bus.run) begin
                        state_d    = ST_RUN;
                        act_mode_d = bus.mode;
                        led_d      = start_value(bus.mode);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (bus.mode != act_mode_q) begin
                        act_mode_d = bus.mode;
                        led_d      = start_value(bus.mode);
                        q_d        = 32'd0;
                        dir_d      = 1'b0;
                    end else if (state_q == ST_RUN) begin
                        if (!bus.run) begin
                            state_d = ST_PAUSE;
                        end else if (due_s) begin
                            {wrap_d, dir_d, led_d} = adv_s;
                            q_d    = 32'd0;
                            tick_d = 1'b1;
                        end else begin
                            q_d = q_q + 32'd1;
                        end
                    end else begin
                        if (bus.run) begin
                            state_d = ST_RUN;
                        end else if (bus.step) begin
                            {wrap_d, dir_d, led_d} = adv_s;
                            q_d    = 32'd0;
                            tick_d = 1'b1;
                        end else begin
                            state_d = ST_PAUSE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = 8'h00;
                    q_d     = 32'd0;
                    dir_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q      <= 8'h00;
            state_q    <= ST_IDLE;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            q_q        <= 32'd0;
            act_mode_q <= MODE_FILL;
            dir_q      <= 1'b0;
        end else begin
            led_q      <= led_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            q_q        <= q_d;
            act_mode_q <= act_mode_d;
            dir_q      <= dir_d;
        end
    end

    assign bus.LEDOut = led_q;
    assign bus.state  = state_q;
    assign bus.tick   = tick_q;
    assign bus.wrap   = wrap_q;

endmodule
